// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one pipelined memory port between instruction fetch and the data
// (load/store) stage. The port has a fixed 2-cycle read latency. At most one
// request is granted per cycle. A 2-deep owner-tag pipe follows each read so
// that its response returns to the side that issued it.
//
// Arbitration: data normally wins a conflict. After the fetch side has been
// denied MAX_WAIT consecutive cycles, fetch wins once.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   clk_en            global clock enable (grants, tags and counters advance only when high)
//   i_req/i_addr      fetch read request
//   i_flush           drops in-flight fetch responses
//   i_grant/i_stall   fetch issued / fetch blocked this cycle
//   i_rvalid/i_rdata  fetch response
//   d_req/d_we/d_addr/d_wdata   data request (d_we == 0 means read)
//   d_grant/d_stall   data issued / data blocked this cycle
//   d_rvalid/d_rdata  load response
//   mem_en/mem_addr/mem_we/mem_wdata   memory request side
//   mem_rdata         memory read data, valid 2 cycles after the issuing mem_en
//   conflict_cnt, starve_cnt   performance counters (only with ARB_PERF_CNT_EN)
//
// Optional feature macro: ARB_PERF_CNT_EN
//   When defined, two 32-bit wrapping counters are added:
//     conflict_cnt - clk_en cycles where both sides request
//     starve_cnt   - clk_en cycles where fetch wins a conflict by starvation

module mem_port_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic        i_grant,
    output logic        i_stall,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_grant,
    output logic        d_stall,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

`ifdef ARB_PERF_CNT_EN
    output logic [31:0] conflict_cnt,
    output logic [31:0] starve_cnt,
`endif

    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              tag1_vld_q, tag1_vld_d;
    logic              tag1_own_q, tag1_own_d;   // 0 = fetch, 1 = data
    logic              tag2_vld_q, tag2_vld_d;
    logic              tag2_own_q, tag2_own_d;

    logic              fetch_win;
    logic              starve_win;

`ifdef ARB_PERF_CNT_EN
    logic [31:0]       conflict_cnt_q, conflict_cnt_d;
    logic [31:0]       starve_cnt_q, starve_cnt_d;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            tag1_vld_q <= 1'b0;
            tag1_own_q <= 1'b0;
            tag2_vld_q <= 1'b0;
            tag2_own_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            tag1_vld_q <= tag1_vld_d;
            tag1_own_q <= tag1_own_d;
            tag2_vld_q <= tag2_vld_d;
            tag2_own_q <= tag2_own_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
            starve_cnt_q   <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            starve_cnt_q   <= starve_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        tag1_vld_d = tag1_vld_q;
        tag1_own_d = tag1_own_q;
        tag2_vld_d = tag2_vld_q;
        tag2_own_d = tag2_own_q;

        if (clk_en) begin
            if (!i_req || i_grant) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != MAX_WAIT_C) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end

            // Writes occupy the port but produce no response. A fetch issued
            // in the same cycle as a flush is dropped immediately.
            tag1_vld_d = (i_grant && !i_flush) || (d_grant && (d_we == 4'h0));
            tag1_own_d = d_grant;

            // Fetch entry leaving tag1 during a flush is killed; the entry
            // currently in tag2 is masked at the output instead.
            tag2_vld_d = tag1_vld_q && !(i_flush && !tag1_own_q);
            tag2_own_d = tag1_own_q;
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        starve_cnt_d   = starve_cnt_q;
        if (clk_en && i_req && d_req) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
        if (clk_en && starve_win) begin
            starve_cnt_d = starve_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign starve_cnt   = starve_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Output logic: arbitration, port mux, response routing
    // ------------------------------------------------------------------
    always_comb begin
        starve_win = i_req && d_req && (wait_cnt_q == MAX_WAIT_C);
        fetch_win  = i_req && (!d_req || starve_win);

        i_grant = clk_en && fetch_win;
        d_grant = clk_en && d_req && !fetch_win;
        i_stall = i_req && !i_grant;
        d_stall = d_req && !d_grant;
        mem_en  = i_grant || d_grant;

        mem_addr  = 32'h0;
        mem_we    = 4'h0;
        mem_wdata = 32'h0;
        if (i_grant) begin
            mem_addr = i_addr;
        end else if (d_grant) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
        end

        i_rvalid = tag2_vld_q && !tag2_own_q && !i_flush;
        d_rvalid = tag2_vld_q && tag2_own_q;
        i_rdata  = mem_rdata;
        d_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        i_req, i_flush, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_we;
    logic        i_grant, i_stall, i_rvalid, d_grant, d_stall, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt, starve_cnt;
    int          exp_conflict, exp_starve;
`endif

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_flush  (i_flush),
        .i_grant  (i_grant),
        .i_stall  (i_stall),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_grant  (d_grant),
        .d_stall  (d_stall),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
`ifdef ARB_PERF_CNT_EN
        .conflict_cnt (conflict_cnt),
        .starve_cnt   (starve_cnt),
`endif
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: 2-cycle pipeline, data is a fixed function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    logic [31:0] ma1, ma2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma1 <= 32'h0;
            ma2 <= 32'h0;
        end else if (clk_en) begin
            ma1 <= mem_en ? mem_addr : 32'h0;
            ma2 <= ma1;
        end
    end
    assign mem_rdata = mem_fn(ma2);

    int edge_n;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else if (clk_en) edge_n <= edge_n + 1;
    end

    typedef struct {
        int          due;
        bit          own;
        logic [31:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_wait = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit en, input bit ir, input logic [31:0] ia, input bit fl,
                        input bit dr, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dd);
        bit          fw, eig, edg, eiv, edv;
        logic [31:0] edat, eaddr;
        rsp_t        r;
        @(negedge clk);
        clk_en = en; i_req = ir; i_addr = ia; i_flush = fl;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
        fw  = ir && (!dr || exp_wait == MAX_WAIT);
        eig = en && fw;
        edg = en && dr && !fw;
        eaddr = eig ? ia : (edg ? da : 32'h0);
        chk_val("i_grant",   32'(i_grant), 32'(eig));
        chk_val("d_grant",   32'(d_grant), 32'(edg));
        chk_val("i_stall",   32'(i_stall), 32'(ir && !eig));
        chk_val("d_stall",   32'(d_stall), 32'(dr && !edg));
        chk_val("mem_en",    32'(mem_en),  32'(eig || edg));
        chk_val("mem_addr",  mem_addr, eaddr);
        chk_val("mem_we",    32'(mem_we), 32'(edg ? dw : 4'h0));
        chk_val("mem_wdata", mem_wdata, edg ? dd : 32'h0);

        if (fl) begin
            for (int k = sb.size() - 1; k >= 0; k--)
                if (!sb[k].own) sb.delete(k);
        end
        eiv = 1'b0; edv = 1'b0; edat = 32'h0;
        if (sb.size() > 0 && sb[0].due == edge_n) begin
            eiv  = !sb[0].own;
            edv  = sb[0].own;
            edat = sb[0].data;
        end
        chk_val("i_rvalid", 32'(i_rvalid), 32'(eiv));
        chk_val("d_rvalid", 32'(d_rvalid), 32'(edv));
        if (eiv) chk_val("i_rdata", i_rdata, edat);
        if (edv) chk_val("d_rdata", d_rdata, edat);
        if (en && (eiv || edv)) void'(sb.pop_front());

        if (eig && !fl) begin
            r.due = edge_n + 2; r.own = 1'b0; r.data = mem_fn(ia);
            sb.push_back(r);
        end
        if (edg && dw == 4'h0) begin
            r.due = edge_n + 2; r.own = 1'b1; r.data = mem_fn(da);
            sb.push_back(r);
        end
        if (en) begin
            if (!ir || eig) exp_wait = 0;
            else if (exp_wait < MAX_WAIT) exp_wait++;
`ifdef ARB_PERF_CNT_EN
            if (ir && dr) exp_conflict++;
            if (ir && dr && exp_wait == 0 && eig) exp_starve++;
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_val("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        chk_val("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        sb.delete();
        exp_wait = 0;
        @(negedge clk);
        #1;
        chk_val("rst_hold_i_rvalid", 32'(i_rvalid), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1;
        i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
        d_req = 1'b0; d_we = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
`ifdef ARB_PERF_CNT_EN
        exp_conflict = 0; exp_starve = 0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk_val("reset_mem_en",  32'(mem_en),  32'h0);
        chk_val("reset_i_grant", 32'(i_grant), 32'h0);
        chk_val("reset_d_grant", 32'(d_grant), 32'h0);
        chk_val("reset_i_stall", 32'(i_stall), 32'h0);
        chk_val("reset_i_rvalid",32'(i_rvalid),32'h0);
        chk_val("reset_d_rvalid",32'(d_rvalid),32'h0);
        rst = 1'b0;
        idle(2);

        // Back-to-back fetch reads
        step(1, 1, 32'h400, 0, 0, 4'h0, 32'h0, 32'h0);
        step(1, 1, 32'h404, 0, 0, 4'h0, 32'h0, 32'h0);
        step(1, 1, 32'h408, 0, 0, 4'h0, 32'h0, 32'h0);
        idle(3);

        // Conflict: data wins 3 times, then fetch by starvation, then data again
        for (int k = 0; k < 6; k++)
            step(1, 1, 32'h500, 0, 1, 4'h0, 32'h3000 + 32'(k * 4), 32'h0);
        idle(3);

        // Fetch read then flush; data read in the flush cycle survives
        step(1, 1, 32'h600, 0, 0, 4'h0, 32'h0, 32'h0);
        step(1, 0, 32'h0,   1, 1, 4'h0, 32'h2000, 32'h0);
        idle(3);
        // Fetch granted in the flush cycle is dropped
        step(1, 1, 32'h700, 1, 0, 4'h0, 32'h0, 32'h0);
        idle(3);

        // Data write: port driven, no response
        step(1, 0, 32'h0, 0, 1, 4'hF, 32'h1000, 32'hDEAD_BEEF);
        idle(3);

        // Clock-enable hold with a read in flight
        step(1, 1, 32'h800, 0, 0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) step(0, 1, 32'h804, 0, 1, 4'h0, 32'h2004, 32'h0);
        idle(3);

        // Reset during the hold kills the in-flight read
        step(1, 1, 32'h900, 0, 0, 4'h0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        apply_reset();
        idle(4);

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            bit en, ir, dr, fl;
            en = ($urandom_range(0, 7) != 0);
            ir = $urandom_range(0, 1) == 1;
            dr = $urandom_range(0, 1) == 1;
            fl = en && ($urandom_range(0, 9) == 0);
            step(en, ir, {$urandom_range(0, 255), 2'b00}, fl, dr,
                 ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(1, 15))) : 4'h0,
                 {$urandom_range(0, 255), 2'b00} + 32'h4000, $urandom());
        end
        idle(3);

`ifdef ARB_PERF_CNT_EN
        chk_val("conflict_cnt", conflict_cnt, 32'(exp_conflict));
        chk_val("starve_cnt",   starve_cnt,   32'(exp_starve));
`endif
        chk_val("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single pipelined, 2-cycle-latency memory port between instruction fetch and the data (load/store) stage.
- Grants at most one request per cycle and drives the memory port.
- Tracks in-flight reads in a 2-deep owner-tag pipe so each read response is returned to the requester that issued it.
- Generates the fetch-side and data-side stall signals.

Parameters:
- MAX_WAIT, 3: consecutive denied cycles after which the fetch side wins arbitration once. Legal range 1..15.
- WAIT_W, 4: width of the starvation counter. Must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  global clock enable; all state advances only when high
- i_req  in  1  fetch request, read only
- i_addr  in  32  fetch address
- i_flush  in  1  discards in-flight fetch responses
- i_grant  out  1  fetch request issued this cycle
- i_stall  out  1  i_req && !i_grant
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_we  in  4  byte write enables; 0 means read
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_grant  out  1  data request issued this cycle
- d_stall  out  1  d_req && !d_grant
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load data
- mem_en  out  1  memory access strobe
- mem_addr  out  32  memory address
- mem_we  out  4  memory byte write enables
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid 2 cycles after the issuing mem_en

Behaviour:
- Arbitration is combinational in the request cycle.
  - clk_en low: i_grant = d_grant = mem_en = 0.
  - Otherwise, only one side requesting: that side is granted.
  - Both requesting: data wins, unless wait_cnt == MAX_WAIT, in which case fetch wins.
- Starvation counter wait_cnt (WAIT_W bits) updates at each clk_en edge:
  - cleared when !i_req or i_grant;
  - incremented when i_req && !i_grant;
  - saturates at MAX_WAIT.
- Port muxing:
  - mem_addr/mem_we/mem_wdata come from the granted side; fetch drives mem_we = 0.
  - When there is no grant: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Tag pipe has two stages, each holding {valid, owner}, where owner 0 = fetch and 1 = data.
  - On a clk_en edge: tag1 <= {granted read, owner}; tag2 <= tag1.
  - A data write (d_we != 0) loads tag1 with valid = 0.
- Response, combinational from tag2:
  - i_rvalid = tag2.valid && owner == 0 && !i_flush.
  - d_rvalid = tag2.valid && owner == 1.
  - i_rdata = d_rdata = mem_rdata, not gated.
- Read latency: request granted in cycle N, response valid in cycle N+2. Back-to-back reads sustain 1 per cycle.
- i_flush, sampled on a clk_en edge:
  - clears valid on every fetch-owned entry in tag1 and tag2;
  - a fetch granted in the same cycle is also dropped, i.e. tag1 is loaded invalid;
  - data-owned entries are unaffected.
- clk_en low: tags, counter and outputs hold. rvalid keeps reflecting the held tag2; the consumer must also qualify with clk_en.
- Reset, asynchronous: tag1/tag2 invalid, wait_cnt = 0. As a result, all grants, stalls, rvalids and mem_en are 0 unless requests are present.
- Reset mid-transaction drops all in-flight responses; no rvalid follows.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds two 32-bit output ports:
  - conflict_cnt: increments on every clk_en cycle with i_req && d_req.
  - starve_cnt: increments on every clk_en cycle in which fetch wins a conflict by the starvation rule.
- Both counters wrap at 2^32 and reset to 0.
- When undefined: ports absent, no counter logic.

Test Plan:
- Reset held, then released with no requests -> all outputs 0, wait_cnt = 0.
- i_req with i_addr = 0x400, 0x404, 0x408 on consecutive cycles, d_req = 0 -> mem_en = 1 with matching mem_addr each cycle; i_rvalid in cycles 2, 3, 4 carrying mem_rdata.
- i_req and d_req both high, d_we = 0, MAX_WAIT = 3:
  - cycles 0-2: d_grant = 1, i_stall = 1;
  - cycle 3: i_grant = 1, d_stall = 1;
  - cycle 4: d_grant = 1 again.
- Fetch read in cycle 0, i_flush in cycle 1 -> no i_rvalid in cycle 2. A data read issued in cycle 1 still gets d_rvalid in cycle 3.
- Data write (d_we = 4'hF, d_addr = 0x1000, d_wdata = 0xDEADBEEF) -> mem_we = 4'hF with matching addr/data, and no d_rvalid 2 cycles later.
- clk_en low for 3 cycles with a read in tag1 -> no grants, and tags hold. After re-enable, the response arrives one clk_en edge later. Asserting rst during the hold -> response never appears.
